dma_desc_splitter: RTL and testbench



---
 rtl/dma_desc_splitter.sv | 183 ++++++++++++++++++
 tb/tb_dma_desc_splitter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_desc_splitter.sv
// Splits KV-cache transfer requests into burst-sized DMA descriptors that never cross a BOUNDARY page.
// Optional statistics counters are built when DMA_DESC_SPLITTER_STATS_EN is defined.
module dma_desc_splitter #(
  parameter int MAX_CHUNK  = 1024,
  parameter int BOUNDARY   = 4096,
  parameter int BEAT_BYTES = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic [47:0]  req_fpga_addr,
  input  logic [47:0]  req_gpu_addr,
  input  logic [31:0]  req_bytes,
  input  logic [7:0]   req_flags,
  output logic         desc_valid,
  input  logic         desc_ready,
  output logic [127:0] desc_data,
  output logic         req_err,
  output logic         busy
`ifdef DMA_DESC_SPLITTER_STATS_EN
  ,
  output logic [31:0]  stat_req_count,
  output logic [31:0]  stat_desc_count,
  output logic [15:0]  stat_err_count
`endif
);

  localparam int PAGE_W = $clog2(BOUNDARY);
  localparam int BEAT_W = $clog2(BEAT_BYTES);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_t;

  state_t       state_q;
  logic         req_ready_q;
  logic         desc_valid_q;
  logic         req_err_q;
  logic         busy_q;
  logic [127:0] desc_data_q;
  logic [47:0]  fpga_q;
  logic [47:0]  gpu_q;
  logic [31:0]  rem_q;
  logic [5:0]   flags_q;

  logic [47:0]  fpga_d;
  logic [47:0]  gpu_d;
  logic [31:0]  rem_d;
  logic [31:0]  chunk_s;
  logic         last_s;
  logic         req_bad_s;
  logic         accept_s;
  logic         reject_s;
  logic         handshake_s;
  logic         unused_flags_s;

  // Builds one descriptor: the chunk is limited by what remains, the burst cap and the page end.
  function automatic logic [127:0] build_desc(
    input logic [47:0] fa,
    input logic [47:0] ga,
    input logic [31:0] rem,
    input logic [5:0]  fl,
    input logic        first
  );
    logic [31:0] page_left;
    logic [31:0] chunk;
    page_left  = 32'(BOUNDARY) - 32'(fa[PAGE_W-1:0]);
    chunk      = (rem < 32'(MAX_CHUNK)) ? rem : 32'(MAX_CHUNK);
    chunk      = (chunk < page_left) ? chunk : page_left;
    build_desc = {fa, ga, chunk[23:0], (rem == chunk), first, fl};
  endfunction

  // The chunk on offer is read back from the registered descriptor to advance the cursor.
  always_comb begin
    chunk_s     = {8'd0, desc_data_q[31:8]};
    last_s      = desc_data_q[7];
    fpga_d      = fpga_q + {16'd0, chunk_s};
    gpu_d       = gpu_q + {16'd0, chunk_s};
    rem_d       = rem_q - chunk_s;
    req_bad_s   = (req_bytes == 32'd0) ||
                  (req_bytes[BEAT_W-1:0] != {BEAT_W{1'b0}}) ||
                  (req_fpga_addr[BEAT_W-1:0] != {BEAT_W{1'b0}}) ||
                  (req_gpu_addr[BEAT_W-1:0] != {BEAT_W{1'b0}});
    accept_s    = (state_q == S_IDLE) && req_valid && req_ready_q && !req_bad_s;
    reject_s    = (state_q == S_IDLE) && req_valid && req_ready_q && req_bad_s;
    handshake_s = (state_q == S_EMIT) && desc_valid_q && desc_ready;
  end

  assign unused_flags_s = ^req_flags[7:6];

  // Request acceptance, descriptor cursor and all registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      req_ready_q  <= 1'b0;
      desc_valid_q <= 1'b0;
      desc_data_q  <= 128'd0;
      req_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      fpga_q       <= 48'd0;
      gpu_q        <= 48'd0;
      rem_q        <= 32'd0;
      flags_q      <= 6'd0;
    end else begin
      req_err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            fpga_q       <= req_fpga_addr;
            gpu_q        <= req_gpu_addr;
            rem_q        <= req_bytes;
            flags_q      <= req_flags[5:0];
            desc_data_q  <= build_desc(req_fpga_addr, req_gpu_addr, req_bytes,
                                       req_flags[5:0], 1'b1);
            desc_valid_q <= 1'b1;
            req_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= S_EMIT;
          end else begin
            req_err_q    <= reject_s;
            req_ready_q  <= 1'b1;
          end
        end
        S_EMIT: begin
          if (handshake_s) begin
            if (last_s) begin
              state_q      <= S_IDLE;
              desc_valid_q <= 1'b0;
              desc_data_q  <= 128'd0;
              req_ready_q  <= 1'b1;
              busy_q       <= 1'b0;
            end else begin
              fpga_q      <= fpga_d;
              gpu_q       <= gpu_d;
              rem_q       <= rem_d;
              desc_data_q <= build_desc(fpga_d, gpu_d, rem_d, flags_q, 1'b0);
            end
          end else begin
            desc_valid_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= S_IDLE;
          desc_valid_q <= 1'b0;
          req_ready_q  <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign desc_valid = desc_valid_q;
  assign desc_data  = desc_data_q;
  assign req_err    = req_err_q;
  assign busy       = busy_q;

`ifdef DMA_DESC_SPLITTER_STATS_EN
  logic [31:0] stat_req_q;
  logic [31:0] stat_desc_q;
  logic [15:0] stat_err_q;

  // Free-running event counters; they wrap silently on overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_req_q  <= 32'd0;
      stat_desc_q <= 32'd0;
      stat_err_q  <= 16'd0;
    end else begin
      stat_req_q  <= accept_s ? (stat_req_q + 32'd1) : stat_req_q;
      stat_desc_q <= handshake_s ? (stat_desc_q + 32'd1) : stat_desc_q;
      stat_err_q  <= reject_s ? (stat_err_q + 16'd1) : stat_err_q;
    end
  end

  assign stat_req_count  = stat_req_q;
  assign stat_desc_count = stat_desc_q;
  assign stat_err_count  = stat_err_q;
`endif

endmodule

// File: tb/tb_dma_desc_splitter.sv
// Self-checking bench for dma_desc_splitter: directed test-plan cases plus random requests
// checked against a page/chunk splitting reference model.
module tb_dma_desc_splitter;

  localparam int MAXC = 1024;
  localparam int PAGE = 4096;

  logic         clk;
  logic         rst;
  logic         req_valid;
  logic         req_ready;
  logic [47:0]  req_fpga_addr;
  logic [47:0]  req_gpu_addr;
  logic [31:0]  req_bytes;
  logic [7:0]   req_flags;
  logic         desc_valid;
  logic         desc_ready;
  logic [127:0] desc_data;
  logic         req_err;
  logic         busy;
`ifdef DMA_DESC_SPLITTER_STATS_EN
  logic [31:0]  stat_req_count;
  logic [31:0]  stat_desc_count;
  logic [15:0]  stat_err_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_req    = 0;
  int m_desc   = 0;
  int m_err    = 0;
  logic [127:0] exp_q[$];

  dma_desc_splitter #(.MAX_CHUNK(MAXC), .BOUNDARY(PAGE), .BEAT_BYTES(64)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_fpga_addr (req_fpga_addr),
    .req_gpu_addr  (req_gpu_addr),
    .req_bytes     (req_bytes),
    .req_flags     (req_flags),
    .desc_valid    (desc_valid),
    .desc_ready    (desc_ready),
    .desc_data     (desc_data),
    .req_err       (req_err),
    .busy          (busy)
`ifdef DMA_DESC_SPLITTER_STATS_EN
    ,
    .stat_req_count  (stat_req_count),
    .stat_desc_count (stat_desc_count),
    .stat_err_count  (stat_err_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: walk the transfer, cutting at min(remaining, MAXC, bytes left in page).
  task automatic model_split(input logic [47:0] fa, input logic [47:0] ga,
                             input logic [31:0] nb, input logic [7:0] fl);
    logic [63:0] rem;
    logic [63:0] chunk;
    logic [63:0] page_left;
    logic [47:0] a;
    logic [47:0] g;
    logic        first;
    a = fa; g = ga; rem = {32'd0, nb}; first = 1'b1;
    exp_q.delete();
    while (rem != 64'd0) begin
      page_left = 64'(PAGE) - 64'(a % 48'(PAGE));
      chunk = (rem < 64'(MAXC)) ? rem : 64'(MAXC);
      if (page_left < chunk) chunk = page_left;
      exp_q.push_back({a, g, chunk[23:0], (rem == chunk), first, fl[5:0]});
      a = a + chunk[47:0];
      g = g + chunk[47:0];
      rem = rem - chunk;
      first = 1'b0;
    end
  endtask

  // mode 0: always ready, 1: random ready, 2: stall 5 cycles after the first descriptor
  task automatic do_req(input logic [47:0] fa, input logic [47:0] ga, input logic [31:0] nb,
                        input logic [7:0] fl, input int mode,
                        output int ndesc, output logic [127:0] last_d);
    logic [127:0] prev_d;
    logic [127:0] obs_d;
    logic [127:0] exp_d;
    logic         obs_v;
    logic         prev_stall;
    int           cyc;
    int           stalls;
    model_split(fa, ga, nb, fl);
    ndesc = 0; last_d = 128'd0; prev_d = 128'd0; prev_stall = 1'b0; cyc = 0; stalls = 0;
    desc_ready = (mode == 0);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_fpga_addr = fa; req_gpu_addr = ga; req_bytes = nb; req_flags = fl;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_req++;
    @(negedge clk);
    check("first_latency", desc_valid, 1'b1);
    while (exp_q.size() > 0 && cyc < 4000) begin
      obs_v = desc_valid;
      obs_d = desc_data;
      if (prev_stall) check("hold_stable", obs_d, prev_d);
      check("valid_in_emit", obs_v, 1'b1);
      check("busy_in_emit", busy, 1'b1);
      if (obs_v !== 1'b1) break;
      case (mode)
        0: desc_ready = 1'b1;
        1: desc_ready = ($urandom_range(0, 3) != 0);
        default: begin
          if (ndesc == 1 && stalls < 5) begin
            desc_ready = 1'b0;
            stalls++;
          end else begin
            desc_ready = 1'b1;
          end
        end
      endcase
      if (desc_ready) begin
        exp_d = exp_q.pop_front();
        check("desc_data", obs_d, exp_d);
        ndesc++;
        last_d = obs_d;
      end
      prev_stall = !desc_ready;
      prev_d = obs_d;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("desc_drained", exp_q.size(), 0);
    desc_ready = 1'b0;
    check("ready_after_last", req_ready, 1'b1);
    check("valid_after_last", desc_valid, 1'b0);
    check("busy_after_last", busy, 1'b0);
    m_desc += ndesc;
  endtask

  task automatic do_err(input logic [47:0] fa, input logic [47:0] ga, input logic [31:0] nb);
    @(negedge clk);
    check("err_ready_before", req_ready, 1'b1);
    req_valid = 1'b1; req_fpga_addr = fa; req_gpu_addr = ga; req_bytes = nb; req_flags = 8'h00;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    m_err++;
    @(negedge clk);
    check("err_pulse", req_err, 1'b1);
    check("err_ready_during", req_ready, 1'b1);
    check("err_no_desc", desc_valid, 1'b0);
    @(negedge clk);
    check("err_pulse_end", req_err, 1'b0);
    check("err_no_desc_late", desc_valid, 1'b0);
    check("err_not_busy", busy, 1'b0);
  endtask

  initial begin
    int           nd;
    logic [127:0] ld;
    logic [63:0]  r;
    logic [47:0]  fa;
    logic [47:0]  ga;
    logic [31:0]  nb;
    rst = 1'b1; req_valid = 1'b0; desc_ready = 1'b0;
    req_fpga_addr = 48'd0; req_gpu_addr = 48'd0; req_bytes = 32'd0; req_flags = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_desc_valid", desc_valid, 1'b0);
    check("rst_desc_data", desc_data, 128'd0);
    check("rst_req_err", req_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", req_ready, 1'b1);

    // Page-crossing split
    do_req(48'h0F80, 48'h20000, 32'h900, 8'h00, 0, nd, ld);
    check("page_cross_count", nd, 4);
    check("page_cross_last", ld, {48'h1800, 48'h20880, 24'h80, 8'h80});

    // Single small request
    do_req(48'h0, 48'h0, 32'h40, 8'h01, 0, nd, ld);
    check("small_count", nd, 1);
    check("small_bytes", ld[31:8], 24'h40);
    check("small_flags", ld[7:0], 8'hC1);

    // Backpressure mid-stream
    do_req(48'h0F80, 48'h20000, 32'h900, 8'h04, 2, nd, ld);
    check("bp_count", nd, 4);

    // Errors
    do_err(48'h0, 48'h0, 32'h30);
    do_err(48'h0, 48'h0, 32'h0);
    do_err(48'h10, 48'h0, 32'h40);
`ifdef DMA_DESC_SPLITTER_STATS_EN
    check("stat_err_three", stat_err_count, 16'd3);
`endif
    do_err(48'h0, 48'h8, 32'h40);

    // Random requests with random backpressure
    for (int i = 0; i < 25; i++) begin
      r = {$urandom(), $urandom()};
      fa = r[47:0] & ~48'h3F;
      if (i % 5 == 0) fa[47:16] = 32'hFFFF_FFFF;
      r = {$urandom(), $urandom()};
      ga = r[47:0] & ~48'h3F;
      nb = 32'($urandom_range(1, 96)) * 32'd64;
      do_req(fa, ga, nb, 8'($urandom_range(0, 255)), 1, nd, ld);
    end

    // Address wrap at 2^48
    do_req(48'hFFFF_FFFF_FF80, 48'h1000, 32'h100, 8'h00, 0, nd, ld);
    check("wrap_count", nd, 2);
    check("wrap_last", ld, {48'h0, 48'h1080, 24'h80, 8'h80});

    // Reset while the second descriptor is on offer
    model_split(48'h0F80, 48'h20000, 32'h900, 8'h02);
    desc_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_fpga_addr = 48'h0F80; req_gpu_addr = 48'h20000;
    req_bytes = 32'h900; req_flags = 8'h02;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rstmid_first", desc_data, exp_q[0]);
    @(negedge clk);
    check("rstmid_second", desc_data, exp_q[1]);
    rst = 1'b1;
    #1;
    check("rstmid_valid_drop", desc_valid, 1'b0);
    check("rstmid_busy_drop", busy, 1'b0);
    check("rstmid_ready_low", req_ready, 1'b0);
    m_req = 0; m_desc = 0; m_err = 0;
    desc_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstmid_ready_hold", req_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_ready_back", req_ready, 1'b1);
    do_req(48'h0, 48'h0, 32'h40, 8'h00, 0, nd, ld);
    check("post_rst_count", nd, 1);
    check("post_rst_flags", ld[7:6], 2'b11);

`ifdef DMA_DESC_SPLITTER_STATS_EN
    check("stat_req", stat_req_count, 32'(m_req));
    check("stat_desc", stat_desc_count, 32'(m_desc));
    check("stat_err", stat_err_count, 16'(m_err));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
